// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared constants for the byte-stream memory loader.
//   - FSM state encodings (HDR_ADDR, HDR_LEN, DATA, WRITE, DONE)
//   - HDR_FIELD_BYTES: width in bytes of each little-endian header field
//   - addr_width(): word-address width for a given memory depth
package mem_loader_pkg;

  localparam int HDR_FIELD_BYTES = 4;

  localparam logic [2:0] HDR_ADDR = 3'd0;
  localparam logic [2:0] HDR_LEN  = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] WRITE    = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  // Clamped to 1 so a single-word memory still gets a legal port width.
  function automatic int addr_width(input int memsize);
    return (memsize > 1) ? $clog2(memsize) : 1;
  endfunction

endpackage

// File: rtl/mem_loader_byte_packer.sv
// byte_packer: WORDSIZE-byte little-endian shift register.
//   clock, reset_n : clock / synchronous active-low reset
//   push           : accept byte_in this cycle
//   byte_in        : incoming stream byte
//   word_nxt       : assembled word including byte_in (valid when last=1)
//   last           : push of the final byte of a word (word complete)
// Bytes shift in from the top so the first byte of a word lands in [7:0].
module byte_packer #(
  parameter int WORDSIZE = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic [7:0]              byte_in,
  output logic [WORDSIZE*8-1:0]   word_nxt,
  output logic                    last
);

  localparam int IW = (WORDSIZE > 1) ? $clog2(WORDSIZE) : 1;

  logic [IW-1:0] idx;

  assign last = push && (idx == IW'(WORDSIZE - 1));

  always_ff @(posedge clock) begin
    if (!reset_n)  idx <= '0;
    else if (push) idx <= last ? '0 : idx + 1'b1;
  end

  generate
    if (WORDSIZE == 1) begin : g_single
      assign word_nxt = byte_in;
    end else begin : g_shift
      logic [WORDSIZE*8-1:0] word_q;
      assign word_nxt = {byte_in, word_q[WORDSIZE*8-1:8]};
      always_ff @(posedge clock) begin
        if (!reset_n)  word_q <= '0;
        else if (push) word_q <= word_nxt;
      end
    end
  endgenerate

endmodule

// File: rtl/mem_loader.sv
// mem_loader: framed byte stream -> memory write port.
// Frame: 4-byte LE base word address, 4-byte LE word count N, N*WORDSIZE
// payload bytes (LE words). Drives an external generic_mem write port.
//   clock, reset_n : clock / synchronous active-low reset
//   in_data/in_valid/in_ready : byte stream handshake
//   write_en, address, data_o : memory write port (one cycle per word)
//   busy : frame in progress (after first header byte through DONE)
//   done : one-cycle pulse at frame completion
// All outputs are registered; they are computed from the next state.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter  int WORDSIZE = 4,
  parameter  int MEMSIZE  = 32 * 1024,
  localparam int AW       = addr_width(MEMSIZE)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  write_en,
  output logic [AW-1:0]         address,
  output logic [WORDSIZE*8-1:0] data_o,
  output logic                  busy,
  output logic                  done
);

  logic [2:0]  state_q, state_d;
  logic [AW-1:0] ptr_q;
  logic [31:0] rem_q;

  logic accept, hdr_push, data_push, hdr_last, data_last;
  logic [HDR_FIELD_BYTES*8-1:0] hdr_word;
  logic [WORDSIZE*8-1:0]        data_word;

  assign accept    = in_valid && in_ready;
  assign hdr_push  = accept && ((state_q == HDR_ADDR) || (state_q == HDR_LEN));
  assign data_push = accept && (state_q == DATA);

  // One packer serves both header fields; its index wraps after each field.
  byte_packer #(.WORDSIZE(HDR_FIELD_BYTES)) u_hdr_packer (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (hdr_push),
    .byte_in  (in_data),
    .word_nxt (hdr_word),
    .last     (hdr_last)
  );

  byte_packer #(.WORDSIZE(WORDSIZE)) u_data_packer (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (data_push),
    .byte_in  (in_data),
    .word_nxt (data_word),
    .last     (data_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      HDR_ADDR: if (hdr_last)  state_d = HDR_LEN;
      HDR_LEN:  if (hdr_last)  state_d = (hdr_word != '0) ? DATA : DONE;
      DATA:     if (data_last) state_d = WRITE;
      WRITE:    state_d = (rem_q > 32'd1) ? DATA : DONE;
      DONE:     state_d = HDR_ADDR;
      default:  state_d = HDR_ADDR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= HDR_ADDR;
      ptr_q    <= '0;
      rem_q    <= '0;
      in_ready <= 1'b0;
      write_en <= 1'b0;
      address  <= '0;
      data_o   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d == HDR_ADDR) || (state_d == HDR_LEN) || (state_d == DATA);
      write_en <= (state_d == WRITE);
      done     <= (state_d == DONE);
      // Stays high while still in HDR_ADDR once the first byte has arrived;
      // drops when DONE hands back to HDR_ADDR.
      busy     <= (state_d != HDR_ADDR) || ((state_q == HDR_ADDR) && (hdr_push || busy));

      if ((state_q == HDR_ADDR) && hdr_last) ptr_q <= hdr_word[AW-1:0];
      if ((state_q == HDR_LEN)  && hdr_last) rem_q <= hdr_word;

      // Latch the write port on entry to WRITE so it is stable all cycle.
      if (data_last) begin
        data_o  <= data_word;
        address <= ptr_q;
      end

      if (state_q == WRITE) begin
        ptr_q <= ptr_q + 1'b1;   // wraps modulo 2^AW
        rem_q <= rem_q - 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic [7:0]  in_data4, in_data1;
  logic        in_valid4, in_valid1;
  logic        in_ready4, in_ready1, write_en4, write_en1;
  logic        busy4, busy1, done4, done1;
  logic [14:0] address4, address1;
  logic [31:0] data_o4;
  logic [7:0]  data_o1;

  mem_loader #(.WORDSIZE(4), .MEMSIZE(32768)) dut4 (
    .clock(clock), .reset_n(reset_n), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .write_en(write_en4), .address(address4),
    .data_o(data_o4), .busy(busy4), .done(done4));

  mem_loader #(.WORDSIZE(1), .MEMSIZE(32768)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .write_en(write_en1), .address(address1),
    .data_o(data_o1), .busy(busy1), .done(done1));

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Write / done monitors, sampled mid-cycle.
  logic [14:0] wa4[$], wa1[$];
  logic [31:0] wd4[$];
  logic [7:0]  wd1[$];
  int          wc4[$], wc1[$];
  int dn4 = 0, dc4 = 0, rv4 = 0, dn1 = 0, dc1 = 0, rv1 = 0;

  always @(negedge clock) begin
    if (write_en4) begin wa4.push_back(address4); wd4.push_back(data_o4); wc4.push_back(cyc); end
    if (write_en1) begin wa1.push_back(address1); wd1.push_back(data_o1); wc1.push_back(cyc); end
    if (done4) begin dn4 <= dn4 + 1; dc4 <= cyc; end
    if (done1) begin dn1 <= dn1 + 1; dc1 <= cyc; end
    if ((write_en4 || done4) && in_ready4) rv4 <= rv4 + 1;
    if ((write_en1 || done1) && in_ready1) rv1 <= rv1 + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // Present one byte and hold it until accepted (bounded).
  task automatic send(input bit sel, input logic [7:0] b, input int gap);
    int  n;
    logic rdy;
    idle(gap);
    if (sel) begin in_data1 = b; in_valid1 = 1'b1; end
    else     begin in_data4 = b; in_valid4 = 1'b1; end
    n = 0;
    rdy = 1'b0;
    do begin
      @(negedge clock);
      rdy = sel ? in_ready1 : in_ready4;
      @(posedge clock); #1;
      n++;
    end while (!rdy && n < 64);
    in_valid1 = 1'b0;
    in_valid4 = 1'b0;
    last_acc = cyc;
    if (!rdy) begin
      tests_run++; fails++;
      $display("FAIL send_timeout byte=%h in_ready stayed 0", b);
    end
  endtask

  task automatic send_w32(input bit sel, input logic [31:0] w, input int gmax);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++)
      send(sel, v[8*i +: 8], (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0);
  endtask

  task automatic send_hdr(input bit sel, input logic [31:0] base, input logic [31:0] n, input int gmax);
    send_w32(sel, base, gmax);
    send_w32(sel, n, gmax);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_valid4 = 1'b0; in_valid1 = 1'b0; in_data4 = '0; in_data1 = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests_run++; if (in_ready4 !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready4); end
    tests_run++; if (write_en4 !== 1'b0) begin fails++; $display("FAIL reset_write_en got=%b exp=0", write_en4); end
    tests_run++; if (address4 !== 15'h0) begin fails++; $display("FAIL reset_address got=%h exp=0", address4); end
    tests_run++; if (data_o4 !== 32'h0) begin fails++; $display("FAIL reset_data_o got=%h exp=0", data_o4); end
    tests_run++; if (busy4 !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy4); end
    tests_run++; if (done4 !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done4); end
    tests_run++; if (in_ready1 !== 1'b0) begin fails++; $display("FAIL reset_in_ready_ws1 got=%b exp=0", in_ready1); end
    reset_n = 1'b1;
    @(posedge clock); @(negedge clock);
    tests_run++; if (in_ready4 !== 1'b1) begin fails++; $display("FAIL release_in_ready got=%b exp=1", in_ready4); end
    tests_run++; if (busy4 !== 1'b0) begin fails++; $display("FAIL release_busy got=%b exp=0", busy4); end
    @(posedge clock); #1;
  endtask

  task automatic test_basic;
    int w0, d0, a1, a2;
    w0 = wa4.size(); d0 = dn4;
    @(negedge clock);
    tests_run++; if (busy4 !== 1'b0) begin fails++; $display("FAIL basic_busy_idle got=%b exp=0", busy4); end
    @(posedge clock); #1;
    send(0, 8'h10, 0);
    @(negedge clock);
    tests_run++; if (busy4 !== 1'b1) begin fails++; $display("FAIL basic_busy_hdr got=%b exp=1", busy4); end
    @(posedge clock); #1;
    send(0, 8'h00, 0); send(0, 8'h00, 0); send(0, 8'h00, 0);
    send_w32(0, 32'h2, 0);
    send_w32(0, 32'h12345678, 0); a1 = last_acc;
    send_w32(0, 32'h89ABCDEF, 0); a2 = last_acc;
    idle(4);
    tests_run++; if (wa4.size() - w0 !== 2) begin fails++; $display("FAIL basic_nwrites got=%0d exp=2", wa4.size() - w0); end
    tests_run++; if (wa4[w0] !== 15'h0010 || wd4[w0] !== 32'h12345678) begin fails++; $display("FAIL basic_w0 got=%h:%h exp=0010:12345678", wa4[w0], wd4[w0]); end
    tests_run++; if (wa4[w0+1] !== 15'h0011 || wd4[w0+1] !== 32'h89ABCDEF) begin fails++; $display("FAIL basic_w1 got=%h:%h exp=0011:89abcdef", wa4[w0+1], wd4[w0+1]); end
    tests_run++; if (wc4[w0] !== a1 || wc4[w0+1] !== a2) begin fails++; $display("FAIL basic_write_latency got=%0d,%0d exp=%0d,%0d", wc4[w0], wc4[w0+1], a1, a2); end
    tests_run++; if (dn4 - d0 !== 1) begin fails++; $display("FAIL basic_done_count got=%0d exp=1", dn4 - d0); end
    tests_run++; if (dc4 !== a2 + 1) begin fails++; $display("FAIL basic_done_cycle got=%0d exp=%0d", dc4, a2 + 1); end
    @(negedge clock);
    tests_run++; if (busy4 !== 1'b0) begin fails++; $display("FAIL basic_busy_after got=%b exp=0", busy4); end
    @(posedge clock); #1;
  endtask

  task automatic test_zero_len;
    int w0, d0, a;
    w0 = wa4.size(); d0 = dn4;
    send_hdr(0, 32'h5, 32'h0, 0); a = last_acc;
    idle(3);
    tests_run++; if (wa4.size() !== w0) begin fails++; $display("FAIL zero_no_write got=%0d exp=%0d", wa4.size(), w0); end
    tests_run++; if (dn4 - d0 !== 1) begin fails++; $display("FAIL zero_done_count got=%0d exp=1", dn4 - d0); end
    tests_run++; if (dc4 !== a) begin fails++; $display("FAIL zero_done_cycle got=%0d exp=%0d", dc4, a); end
    send_hdr(0, 32'h40, 32'h1, 0);
    send_w32(0, 32'h11223344, 0);
    idle(4);
    tests_run++; if (wa4.size() - w0 !== 1 || wa4[w0] !== 15'h0040 || wd4[w0] !== 32'h11223344) begin
      fails++; $display("FAIL zero_next_frame got=%h:%h exp=0040:11223344", wa4[w0], wd4[w0]); end
  endtask

  task automatic test_wrap;
    int w0;
    w0 = wa4.size();
    send_hdr(0, 32'h7FFF, 32'h2, 0);
    send_w32(0, 32'hA5A50001, 0);
    send_w32(0, 32'hA5A50002, 0);
    idle(4);
    tests_run++; if (wa4[w0] !== 15'h7FFF || wd4[w0] !== 32'hA5A50001) begin fails++; $display("FAIL wrap_first got=%h:%h exp=7fff:a5a50001", wa4[w0], wd4[w0]); end
    tests_run++; if (wa4[w0+1] !== 15'h0000 || wd4[w0+1] !== 32'hA5A50002) begin fails++; $display("FAIL wrap_second got=%h:%h exp=0000:a5a50002", wa4[w0+1], wd4[w0+1]); end
    send_hdr(0, 32'h00018000, 32'h1, 0);
    send_w32(0, 32'h0BADF00D, 0);
    idle(4);
    tests_run++; if (wa4.size() - w0 !== 3 || wa4[w0+2] !== 15'h0000 || wd4[w0+2] !== 32'h0BADF00D) begin
      fails++; $display("FAIL trunc_base got=%h:%h exp=0000:0badf00d", wa4[w0+2], wd4[w0+2]); end
  endtask

  task automatic test_backpressure;
    int w0, d0;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'hDEADBEEF; exp_w[1] = 32'h00FF00FF; exp_w[2] = 32'h13579BDF;
    w0 = wa4.size(); d0 = dn4;
    send_hdr(0, 32'h100, 32'h3, 3);
    for (int i = 0; i < 3; i++) send_w32(0, exp_w[i], 3);
    idle(4);
    tests_run++; if (wa4.size() - w0 !== 3) begin fails++; $display("FAIL bp_nwrites got=%0d exp=3", wa4.size() - w0); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (wa4[w0+i] !== 15'(32'h100 + i) || wd4[w0+i] !== exp_w[i]) begin
        fails++; $display("FAIL bp_word%0d got=%h:%h exp=%h:%h", i, wa4[w0+i], wd4[w0+i], 15'(32'h100 + i), exp_w[i]); end
    end
    tests_run++; if (dn4 - d0 !== 1) begin fails++; $display("FAIL bp_done_count got=%0d exp=1", dn4 - d0); end
    tests_run++; if (rv4 !== 0) begin fails++; $display("FAIL bp_ready_in_write_done got=%0d exp=0", rv4); end
  endtask

  task automatic test_reset_mid;
    int w0, d0;
    w0 = wa4.size(); d0 = dn4;
    send_hdr(0, 32'h30, 32'h3, 0);
    send_w32(0, 32'h01020304, 0);
    send(0, 8'hAA, 0);
    send(0, 8'hBB, 0);
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    send_hdr(0, 32'h20, 32'h1, 0);
    send_w32(0, 32'hCAFEBABE, 0);
    idle(4);
    tests_run++; if (wa4.size() - w0 !== 2) begin fails++; $display("FAIL rstmid_nwrites got=%0d exp=2", wa4.size() - w0); end
    tests_run++; if (wa4[w0] !== 15'h0030 || wd4[w0] !== 32'h01020304) begin fails++; $display("FAIL rstmid_pre got=%h:%h exp=0030:01020304", wa4[w0], wd4[w0]); end
    tests_run++; if (wa4[w0+1] !== 15'h0020 || wd4[w0+1] !== 32'hCAFEBABE) begin fails++; $display("FAIL rstmid_post got=%h:%h exp=0020:cafebabe", wa4[w0+1], wd4[w0+1]); end
    tests_run++; if (dn4 - d0 !== 1) begin fails++; $display("FAIL rstmid_done_count got=%0d exp=1", dn4 - d0); end
  endtask

  task automatic test_ws1;
    int w0, d0;
    int a[3];
    logic [7:0] b [3];
    b[0] = 8'hAA; b[1] = 8'hBB; b[2] = 8'hCC;
    w0 = wa1.size(); d0 = dn1;
    send_hdr(1, 32'h0, 32'h3, 0);
    for (int i = 0; i < 3; i++) begin send(1, b[i], 0); a[i] = last_acc; end
    idle(3);
    tests_run++; if (wa1.size() - w0 !== 3) begin fails++; $display("FAIL ws1_nwrites got=%0d exp=3", wa1.size() - w0); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (wa1[w0+i] !== 15'(i) || wd1[w0+i] !== b[i] || wc1[w0+i] !== a[i]) begin
        fails++; $display("FAIL ws1_write%0d got=%h:%h@%0d exp=%h:%h@%0d", i, wa1[w0+i], wd1[w0+i], wc1[w0+i], 15'(i), b[i], a[i]); end
    end
    tests_run++; if (dn1 - d0 !== 1 || dc1 !== a[2] + 1) begin fails++; $display("FAIL ws1_done got=%0d@%0d exp=1@%0d", dn1 - d0, dc1, a[2] + 1); end
    tests_run++; if (rv1 !== 0) begin fails++; $display("FAIL ws1_ready_in_write_done got=%0d exp=0", rv1); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_len;
    test_wrap;
    test_backpressure;
    test_reset_mid;
    test_ws1;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
